adf4158: RTL and testbench
==========================

ADF4158 -- requirements
Module: adf4158

Interface
REQ-001 Parameter N_WORDS, default 11; number of 32-bit configuration words sent (R7, R6a, R6b, R5a, R5b, R4a, R4b, R3, R2, R1, R0).
REQ-002 Parameter CFG, width N_WORDS*32, default all zero except control bits [2:0] of each word set to its register number; word k = CFG[32k+31:32k], word 0 sent first.
REQ-003 Parameter CE_WAIT, default 16; clk cycles from ce rising to first bit.
REQ-004 clk  in  1  system clock, 40 MHz.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 enable  in  1  level; high starts/holds configuration, low aborts and powers down.
REQ-007 muxout  in  1  asynchronous MUXOUT pin from synthesizer (lock detect).
REQ-008 ce  out  1  chip enable to synthesizer.
REQ-009 le  out  1  load enable; rising edge latches shifted word.
REQ-010 sclk  out  1  serial clock, clk/2 while shifting, else 0.
REQ-011 data  out  1  serial data, MSB first.
REQ-012 txdata  out  1  ramp trigger pin; held 0.
REQ-013 config_done  out  1  high once all words latched.
REQ-014 locked  out  1  muxout after 2-flop synchronizer into clk.

Function
REQ-015 States: IDLE, WAIT, SHIFT, LATCH, GAP, DONE; all outputs registered.
REQ-016 IDLE: enable sampled high at edge T -> ce=1 from T, enter WAIT.
REQ-017 WAIT: CE_WAIT cycles, then SHIFT of word 0.
REQ-018 SHIFT: each bit occupies 2 clk: cycle A data=bit, sclk=0; cycle B same data, sclk=1; bits 31 down to 0; le=0.
REQ-019 LATCH: after bit 0, le=1 for 4 clk, sclk=0, data=0.
REQ-020 GAP: le=0 for 2 clk; then next word's SHIFT, or DONE after word N_WORDS-1.
REQ-021 Per-word time 70 clk; config_done rises at T+CE_WAIT+70*N_WORDS and stays high while enable high.
REQ-022 DONE: ce=1, le=0, sclk=0, data=0.
REQ-023 enable low in any state -> next edge: IDLE, ce=0, le=0, sclk=0, data=0, config_done=0; re-enable restarts from word 0 with full WAIT.
REQ-024 Bit counter 0-31 and word counter 0..N_WORDS-1 never wrap past limits; no partial word latched on abort.
REQ-025 locked independent of state; 2-cycle latency from muxout.

Reset
REQ-026 rst high: state IDLE, counters 0, ce=0, le=0, sclk=0, data=0, txdata=0, config_done=0, locked=0, synchronizer flops 0.
REQ-027 Reset release takes effect on first clk edge after deassertion; enable high at that time starts at REQ-016.

Structure
REQ-028 Package adf4158_pkg: state enum, WORD_WIDTH=32, LE_CYCLES=4, GAP_CYCLES=2, SCLK_DIV=2.
REQ-029 One sub-module adf4158_spi_tx: loads one 32-bit word, serializes data/sclk MSB first, pulses le, reports word done; top-level FSM sequences words and CE.

Verification
REQ-030 Reset then enable=1 with CFG word0=0xA5A5A5A7: ce high at T, first sclk rise at T+CE_WAIT+1, 32 bits sampled on sclk rise = 0xA5A5A5A7, le high 4 cycles.
REQ-031 Default CFG, N_WORDS=11: capture 11 words on le rise; [2:0] sequence 7,6,6,5,5,4,4,3,2,1,0; config_done at T+16+770.
REQ-032 Drop enable at bit 10 of word 3: ce, sclk, le, data 0 next cycle, no le pulse; re-enable -> word 0 resent after 16-cycle wait.
REQ-033 Assert rst mid-LATCH: all outputs 0 immediately (asynchronous), restart after release.
REQ-034 Toggle muxout 0->1: locked rises exactly 2 clk later, in any state; txdata stays 0 throughout.

Source files
------------

// File: rtl/adf4158_pkg.sv
// Shared types and constants for the ADF4158 configuration sequencer.
package adf4158_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int WORD_WIDTH = 32;
  localparam int LE_CYCLES  = 4;
  localparam int GAP_CYCLES = 2;
  localparam int SCLK_DIV   = 2;
  localparam int MAX_WORDS  = 16;

  // Control field of each word in send order R7, R6a, R6b, R5a, R5b, R4a, R4b, R3, R2, R1, R0.
  function automatic logic [2:0] ctrl_bits(input int k);
    case (k)
      0:       return 3'd7;
      1, 2:    return 3'd6;
      3, 4:    return 3'd5;
      5, 6:    return 3'd4;
      7:       return 3'd3;
      8:       return 3'd2;
      9:       return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [MAX_WORDS*WORD_WIDTH-1:0] default_cfg();
    logic [MAX_WORDS*WORD_WIDTH-1:0] c;
    c = '0;
    for (int k = 0; k < 11; k++) c[k*WORD_WIDTH +: 3] = ctrl_bits(k);
    return c;
  endfunction

endpackage

// File: rtl/adf4158_spi_tx.sv
// Serializes one word MSB first (data stable across an sclk period) and drives le.
module adf4158_spi_tx
  import adf4158_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic                  latch_en,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  data,
  output logic                  sclk,
  output logic                  le,
  output logic                  word_shifted
);
  localparam int BW = $clog2(WORD_WIDTH);
  localparam int PW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;

  logic [WORD_WIDTH-1:0] sr;
  logic [BW-1:0]         bit_cnt;
  logic [PW-1:0]         phase;
  logic                  phase_last;

  // The MSB of the shift register is the data pin itself; it is cleared outside SHIFT.
  assign data         = sr[WORD_WIDTH-1];
  assign phase_last   = (phase == PW'(SCLK_DIV - 1));
  assign word_shifted = phase_last && (bit_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      sclk    <= 1'b0;
      le      <= 1'b0;
    end else if (load) begin
      sr      <= word;
      bit_cnt <= BW'(WORD_WIDTH - 1);
      phase   <= '0;
      sclk    <= 1'b0;
      le      <= 1'b0;
    end else if (shift_en) begin
      le <= 1'b0;
      if (phase_last) begin
        phase <= '0;
        sclk  <= 1'b0;
        if (bit_cnt != '0) begin
          bit_cnt <= bit_cnt - 1'b1;
          sr      <= {sr[WORD_WIDTH-2:0], 1'b0};
        end
      end else begin
        phase <= phase + 1'b1;
        sclk  <= (int'(phase) + 1 >= SCLK_DIV / 2);
      end
    end else begin
      sr      <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      sclk    <= 1'b0;
      le      <= latch_en;
    end
  end

endmodule

// File: rtl/adf4158.sv
// ADF4158 power-up configuration sequencer: CE, settle wait, N words over SPI, lock sync.
module adf4158
  import adf4158_pkg::*;
#(
  parameter int                               N_WORDS = 11,
  parameter logic [N_WORDS*WORD_WIDTH-1:0]    CFG     = (N_WORDS*WORD_WIDTH)'(default_cfg()),
  parameter int                               CE_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       muxout,
  output logic       ce,
  output logic       le,
  output logic       sclk,
  output logic       data,
  output logic       txdata,
  output logic       config_done,
  output logic       locked,
  output logic [2:0] dbg_state
);
  localparam int WCW = $clog2(N_WORDS + 1);

  state_t                        state, state_next;
  logic [15:0]                   cnt;
  logic [WCW-1:0]                word_cnt, word_next;
  logic                          word_shifted;
  logic                          mux_meta;
  logic [WORD_WIDTH-1:0]         word;
  logic [N_WORDS*WORD_WIDTH-1:0] cfg_bits;

  assign cfg_bits  = CFG;
  // Indexed by the next word so the serializer loads the right word on the SHIFT entry edge.
  assign word      = cfg_bits[word_next*WORD_WIDTH +: WORD_WIDTH];
  assign txdata    = 1'b0;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    word_next  = word_cnt;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  state_next = WAIT;
        WAIT:  if (cnt == 16'(CE_WAIT - 1)) state_next = SHIFT;
        SHIFT: if (word_shifted) state_next = LATCH;
        LATCH: if (cnt == 16'(LE_CYCLES - 1)) state_next = GAP;
        GAP: begin
          if (cnt == 16'(GAP_CYCLES - 1)) begin
            if (word_cnt == WCW'(N_WORDS - 1)) begin
              state_next = DONE;
            end else begin
              state_next = SHIFT;
              word_next  = word_cnt + 1'b1;
            end
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
    if (state_next == IDLE) word_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      word_cnt    <= '0;
      ce          <= 1'b0;
      config_done <= 1'b0;
    end else begin
      state       <= state_next;
      word_cnt    <= word_next;
      ce          <= (state_next != IDLE);
      config_done <= (state_next == DONE);
      if (state_next != state || state_next == IDLE || state_next == DONE) cnt <= '0;
      else cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_meta <= 1'b0;
      locked   <= 1'b0;
    end else begin
      mux_meta <= muxout;
      locked   <= mux_meta;
    end
  end

  adf4158_spi_tx u_spi_tx (
    .clk          (clk),
    .rst          (rst),
    .load         ((state_next == SHIFT) && (state != SHIFT)),
    .shift_en     (state_next == SHIFT),
    .latch_en     (state_next == LATCH),
    .word         (word),
    .data         (data),
    .sclk         (sclk),
    .le           (le),
    .word_shifted (word_shifted)
  );

endmodule

// File: tb/tb_adf4158.sv
// Bench for adf4158: SPI word capture against an expected-word queue plus timing checks.
`timescale 1ns/1ps
module tb_adf4158;
  import adf4158_pkg::*;

  localparam int N_WORDS     = 11;
  localparam int CE_WAIT     = 16;
  localparam int WORD_CYCLES = 70;
  localparam int LE_LEN      = 4;
  localparam int FIRST_SCLK  = CE_WAIT + 1;
  localparam int DONE_AT     = CE_WAIT + WORD_CYCLES * N_WORDS;
  localparam int ABORT_AT    = CE_WAIT + 3 * WORD_CYCLES + 2 * (31 - 10);

  function automatic logic [2:0] exp_ctrl(input int k);
    logic [2:0] tab [11];
    tab = '{3'd7, 3'd6, 3'd6, 3'd5, 3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    return tab[k];
  endfunction

  function automatic logic [31:0] word_of(input int k);
    logic [31:0] w;
    if (k == 0) return 32'hA5A5_A5A7;
    w = 32'h5A3C_0000 ^ (32'(k) << 20) ^ (32'(k) << 8) ^ 32'h0000_00F0;
    w[2:0] = exp_ctrl(k);
    return w;
  endfunction

  function automatic logic [N_WORDS*32-1:0] build_cfg();
    logic [N_WORDS*32-1:0] c;
    for (int k = 0; k < N_WORDS; k++) c[k*32 +: 32] = word_of(k);
    return c;
  endfunction

  localparam logic [N_WORDS*32-1:0] TB_CFG = build_cfg();

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic muxout = 1'b0;
  logic ce, le, sclk, data, txdata, config_done, locked;
  logic [2:0] dbg_state;

  int checks = 0;
  int passed = 0;
  int txdata_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cap = '0;
  int nbits = 0;
  int le_len = 0;
  logic sclk_d = 1'b0;
  logic le_d = 1'b0;

  adf4158 #(.N_WORDS(N_WORDS), .CFG(TB_CFG), .CE_WAIT(CE_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .muxout      (muxout),
    .ce          (ce),
    .le          (le),
    .sclk        (sclk),
    .data        (data),
    .txdata      (txdata),
    .config_done (config_done),
    .locked      (locked),
    .dbg_state   (dbg_state)
  );

  always #12.5 clk = ~clk;

  // Scoreboard: capture data on sclk rise, compare the word on each le rise.
  always @(negedge clk) begin
    logic [31:0] w;
    if (txdata !== 1'b0) txdata_bad++;
    if (rst) begin
      nbits  = 0;
      le_len = 0;
    end else begin
      if (!ce) nbits = 0;
      else if (sclk && !sclk_d) begin
        cap = {cap[30:0], data};
        nbits++;
      end
      if (le && !le_d) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_le: got word %h with no word expected", cap);
        end else begin
          w = exp_q.pop_front();
          if (cap !== w || nbits != 32)
            $display("FAIL spi_word: got %h (%0d bits) expected %h (32 bits)", cap, nbits, w);
          else passed++;
        end
        nbits  = 0;
        le_len = 0;
      end
      if (le) le_len++;
      else if (le_d && le_len != 0) begin
        checks++;
        if (le_len != LE_LEN) $display("FAIL le_width: got %0d cycles expected %0d", le_len, LE_LEN);
        else passed++;
        le_len = 0;
      end
    end
    sclk_d = sclk;
    le_d   = le;
  end

  task automatic run_config(input bit release_rst, output int first_sclk, output int first_done);
    first_sclk = -1;
    first_done = -1;
    for (int k = 0; k < N_WORDS; k++) exp_q.push_back(word_of(k));
    @(negedge clk);
    if (release_rst) rst = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < DONE_AT + 50; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        checks++;
        if (ce !== 1'b1) $display("FAIL ce_at_start: got %b expected 1", ce);
        else passed++;
      end
      if (first_sclk < 0 && sclk === 1'b1) first_sclk = c;
      if (config_done === 1'b1) begin
        first_done = c;
        break;
      end
    end
  endtask

  task automatic check_run(input string tag, input int first_sclk, input int first_done);
    checks++;
    if (first_sclk != FIRST_SCLK)
      $display("FAIL %s_first_sclk: got cycle %0d expected %0d", tag, first_sclk, FIRST_SCLK);
    else passed++;
    checks++;
    if (first_done != DONE_AT)
      $display("FAIL %s_config_done: got cycle %0d expected %0d", tag, first_done, DONE_AT);
    else passed++;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_words_left: got %0d unsent expected 0", tag, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    muxout = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ce, le, sclk, data, txdata, config_done, locked} !== 7'b0)
      $display("FAIL reset_outputs: got %b expected 0000000",
               {ce, le, sclk, data, txdata, config_done, locked});
    else passed++;
    checks++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    else passed++;
    muxout = 1'b0;
  endtask

  task automatic test_full_config();
    int fs, fd;
    int bad;
    run_config(1'b1, fs, fd);
    check_run("full", fs, fd);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if ({config_done, ce, le, sclk, data} !== 5'b11000) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL done_hold: got %0d bad cycles expected 0", bad);
    else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] w3;
    int fs, fd;
    int le_seen;
    w3 = word_of(3);
    @(negedge clk); enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ce, config_done} !== 2'b00) $display("FAIL disable_done: got %b expected 00", {ce, config_done});
    else passed++;
    for (int k = 0; k < 3; k++) exp_q.push_back(word_of(k));
    @(negedge clk); enable = 1'b1;
    for (int c = 0; c <= ABORT_AT; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({ce, sclk, le, data} !== {3'b100, w3[10]})
      $display("FAIL abort_bit10: got %b expected %b", {ce, sclk, le, data}, {3'b100, w3[10]});
    else passed++;
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ce, sclk, le, data, dbg_state} !== {4'b0000, IDLE})
      $display("FAIL abort_outputs: got %b expected %b", {ce, sclk, le, data, dbg_state}, {4'b0000, IDLE});
    else passed++;
    le_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (le !== 1'b0) le_seen++;
    end
    checks++;
    if (le_seen != 0 || exp_q.size() != 0)
      $display("FAIL abort_no_latch: got %0d le cycles, %0d words left expected 0, 0", le_seen, exp_q.size());
    else passed++;
    run_config(1'b0, fs, fd);
    check_run("reenable", fs, fd);
  endtask

  task automatic test_reset_mid_latch();
    int fs, fd;
    int waited;
    @(negedge clk); enable = 1'b0; muxout = 1'b1;
    repeat (3) @(posedge clk);
    exp_q.push_back(word_of(0));
    @(negedge clk); enable = 1'b1;
    waited = 0;
    while (le !== 1'b1 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (le !== 1'b1) $display("FAIL latch_timeout: got le=%b expected 1 within 200 cycles", le);
    else passed++;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({ce, le, sclk, data, txdata, config_done, locked} !== 7'b0)
      $display("FAIL async_reset: got %b expected 0000000",
               {ce, le, sclk, data, txdata, config_done, locked});
    else passed++;
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL prereset_words: got %0d left expected 0", exp_q.size());
    else passed++;
    run_config(1'b1, fs, fd);
    check_run("post_reset", fs, fd);
  endtask

  task automatic test_locked();
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); enable = (s == 1); muxout = 1'b0;
      repeat (25) @(posedge clk);
      #2 muxout = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (locked !== 1'b0) $display("FAIL locked_rise_early_%0d: got %b expected 0", s, locked);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (locked !== 1'b1) $display("FAIL locked_rise_%0d: got %b expected 1", s, locked);
      else passed++;
      #2 muxout = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (locked !== 1'b0) $display("FAIL locked_fall_%0d: got %b expected 0", s, locked);
      else passed++;
    end
    @(negedge clk); enable = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_config();
    test_abort();
    test_reset_mid_latch();
    test_locked();
    repeat (2) @(posedge clk);
    checks++;
    if (txdata_bad != 0) $display("FAIL txdata_low: got %0d high cycles expected 0", txdata_bad);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
